cmd_uart_tx: RTL and testbench
==============================

Name: cmd_uart_tx

Overview:
- Downstream consumer of the 8-bit command code produced by the 4-bit digit-to-command mapper. Valid command codes are 0x01..0x08.
- Serialises the current command as one 8N1 UART frame toward the robot motor controller.
- Sends when the command changes and on an explicit resend strobe. Rapid changes coalesce, so only the most recent command goes out.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
- IDLE_LEVEL, 1'b1, line level driven on oTX when no frame is in flight.

Ports:
- iCLK  input  1  system clock; all logic on rising edge.
- iRST  input  1  synchronous, active-high reset.
- iCMD  input  8  command code from the digit mapper; sampled only in IDLE.
- iSEND  input  1  single-cycle strobe that forces retransmission of the current iCMD.
- oTX  output  1  UART serial line.
- oBUSY  output  1  high from START entry through the end of STOP.
- oDONE  output  1  one-cycle pulse on the cycle after the stop bit completes.
- oLAST_CMD  output  8  last byte whose frame completed.

Behaviour:
- Reset (iRST=1 at a clock edge) forces, on that edge:
  - state=IDLE, oTX=IDLE_LEVEL, oBUSY=0, oDONE=0.
  - oLAST_CMD=8'h00, baud counter=0, bit index=0, shift register=0, resend_pending=0.
- Reset has priority over every other event, including mid-frame. The line returns to idle on the same edge, the partial frame is abandoned, and no oDONE is issued.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - A request exists when iCMD != oLAST_CMD, or iSEND=1, or resend_pending=1.
  - On a request at edge N: latch iCMD into the shift register, clear resend_pending, go to START. oTX=0 and oBUSY=1 from edge N.
  - Because oLAST_CMD resets to 0 and valid codes are nonzero, the first valid command after reset always transmits.
- START: hold oTX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Drive shift-register bit[index], LSB first, for CLKS_PER_BIT cycles per bit.
  - After bit 7, go to STOP.
- STOP:
  - Hold oTX=1 for CLKS_PER_BIT cycles.
  - On the final cycle: oLAST_CMD <= latched byte, oBUSY <= 0, oDONE <= 1 for exactly one cycle, go to IDLE.
- Baud counter:
  - 16-bit, counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - The frame is exactly 10*CLKS_PER_BIT cycles from oTX falling to re-entry into IDLE.
- Busy-time events:
  - Changes to iCMD while oBUSY=1 are ignored by the current frame, which stays stable.
  - After return to IDLE, the compare against oLAST_CMD picks up the newest value. Intermediate values are never sent.
- Resend strobe:
  - iSEND=1 while busy sets resend_pending, serviced on the first IDLE cycle.
  - Multiple strobes during one frame collapse into a single resend.
- Back-to-back frames:
  - If a request is present on the first IDLE cycle, the next START begins on the following edge.
  - Minimum inter-frame idle time is 1 cycle, with oTX=1 during it.
- iSEND and a command change in the same IDLE cycle produce one frame carrying the current iCMD.

Test Plan:
- Default command after reset: CLKS_PER_BIT=4. Assert iRST 3 cycles, release, iCMD=8'h08 held -> oTX low 1 cycle after release, then 40-cycle frame 0,0,0,0,1,0,0,0,0,1 (start, LSB first, stop). oDONE pulses once; oLAST_CMD=8'h08; no further frame while iCMD is stable.
- Coalescing: CLKS_PER_BIT=4, oLAST_CMD=8'h08. Set iCMD=8'h03, then mid-frame change to 8'h05 and then 8'h01 -> first frame carries 0x03 unchanged; exactly one more frame carries 0x01; 0x05 is never sent.
- Resend strobes: CLKS_PER_BIT=4, idle with iCMD=oLAST_CMD=8'h02. Pulse iSEND once in IDLE and twice during the resulting frame -> exactly two frames of 0x02, separated by exactly 1 idle cycle.
- Reset mid-frame: CLKS_PER_BIT=4. Assert iRST during data bit 3 of a 0x06 frame -> oTX=1, oBUSY=0, oLAST_CMD=0 on that edge, no oDONE pulse. After release, a full 0x06 frame is sent.
- Timing at default: CLKS_PER_BIT=5208, iCMD 0x08 -> 0x07 -> oBUSY high for exactly 52080 cycles; each oTX bit level is stable for exactly 5208 cycles.

Source files
------------

// File: rtl/cmd_uart_tx.sv
// -----------------------------------------------------------------------------
// cmd_uart_tx
// Serialises the current robot command code as one 8N1 UART frame
// (start bit, 8 data bits LSB first, stop bit). A frame is launched whenever
// the command differs from the last byte that went out completely, or when a
// resend is requested. Changes while a frame is in flight are not queued, so
// only the newest command is sent once the line is free again.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   IDLE_LEVEL    level driven on oTX while no frame is in flight
//
// Ports:
//   iCLK       in   system clock, rising edge
//   iRST       in   synchronous active-high reset
//   iCMD[7:0]  in   command code, sampled only while idle
//   iSEND      in   one-cycle strobe forcing a retransmission of iCMD
//   oTX        out  UART serial line (registered)
//   oBUSY      out  high from start-bit entry through the end of the stop bit
//   oDONE      out  one-cycle pulse after the stop bit completes
//   oLAST_CMD  out  last byte whose frame completed
// -----------------------------------------------------------------------------
module cmd_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iCMD,
  input  logic       iSEND,
  output logic       oTX,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [7:0] oLAST_CMD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Baud counter value on the last cycle of every bit.
  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 32'd1);

  state_t      state_r;
  logic [15:0] baudCnt_r;
  logic [2:0]  bitIdx_r;
  logic [7:0]  shiftReg_r;
  logic        resendPending_r;

  logic        bitEnd_s;
  logic        request_s;
  logic [2:0]  nextIdx_s;

  assign bitEnd_s  = (baudCnt_r == LAST_TICK);
  // oLAST_CMD resets to zero and valid codes are nonzero, so the first real
  // command after reset always counts as a change.
  assign request_s = (iCMD != oLAST_CMD) || iSEND || resendPending_r;
  assign nextIdx_s = bitIdx_r + 3'd1;

  // Frame sequencer: state, baud timing, data shifting and all registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r         <= IDLE;
      baudCnt_r       <= 16'd0;
      bitIdx_r        <= 3'd0;
      shiftReg_r      <= 8'h00;
      resendPending_r <= 1'b0;
      oTX             <= IDLE_LEVEL;
      oBUSY           <= 1'b0;
      oDONE           <= 1'b0;
      oLAST_CMD       <= 8'h00;
    end else begin
      oDONE <= 1'b0;

      // Strobes while busy collapse into a single pending resend.
      if ((state_r != IDLE) && iSEND) begin
        resendPending_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          baudCnt_r <= 16'd0;
          bitIdx_r  <= 3'd0;
          oTX       <= IDLE_LEVEL;
          oBUSY     <= 1'b0;
          if (request_s) begin
            shiftReg_r      <= iCMD;
            resendPending_r <= 1'b0;
            state_r         <= START;
            oTX             <= 1'b0;
            oBUSY           <= 1'b1;
          end
        end

        START: begin
          if (bitEnd_s) begin
            baudCnt_r <= 16'd0;
            bitIdx_r  <= 3'd0;
            oTX       <= shiftReg_r[0];
            state_r   <= DATA;
          end else begin
            baudCnt_r <= baudCnt_r + 16'd1;
          end
        end

        DATA: begin
          if (bitEnd_s) begin
            baudCnt_r <= 16'd0;
            if (bitIdx_r == 3'd7) begin
              oTX     <= 1'b1;
              state_r <= STOP;
            end else begin
              bitIdx_r <= nextIdx_s;
              oTX      <= shiftReg_r[nextIdx_s];
            end
          end else begin
            baudCnt_r <= baudCnt_r + 16'd1;
          end
        end

        STOP: begin
          if (bitEnd_s) begin
            baudCnt_r <= 16'd0;
            oLAST_CMD <= shiftReg_r;
            oBUSY     <= 1'b0;
            oDONE     <= 1'b1;
            oTX       <= IDLE_LEVEL;
            state_r   <= IDLE;
          end else begin
            baudCnt_r <= baudCnt_r + 16'd1;
          end
        end

        default: begin
          state_r   <= IDLE;
          baudCnt_r <= 16'd0;
          bitIdx_r  <= 3'd0;
          oTX       <= IDLE_LEVEL;
          oBUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_cmd_uart_tx
// Directed bench for cmd_uart_tx. A fast instance (4 clocks per bit) covers
// frame content, coalescing, resend strobes and reset; a second instance at
// the default 5208 clocks per bit covers frame and bit timing.
// -----------------------------------------------------------------------------
module tb_cmd_uart_tx;

  localparam int FAST_CPB = 4;
  localparam int SLOW_CPB = 5208;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fast instance signals
  logic       rst;
  logic [7:0] cmd;
  logic       send;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] lastCmd;

  // Slow instance signals
  logic       rstS;
  logic [7:0] cmdS;
  logic       sendS;
  logic       txS;
  logic       busyS;
  logic       doneS;
  logic [7:0] lastS;

  cmd_uart_tx #(.CLKS_PER_BIT(FAST_CPB), .IDLE_LEVEL(1'b1)) dutFast (
    .iCLK      (clk),
    .iRST      (rst),
    .iCMD      (cmd),
    .iSEND     (send),
    .oTX       (tx),
    .oBUSY     (busy),
    .oDONE     (done),
    .oLAST_CMD (lastCmd)
  );

  cmd_uart_tx #(.CLKS_PER_BIT(SLOW_CPB), .IDLE_LEVEL(1'b1)) dutSlow (
    .iCLK      (clk),
    .iRST      (rstS),
    .iCMD      (cmdS),
    .iSEND     (sendS),
    .oTX       (txS),
    .oBUSY     (busyS),
    .oDONE     (doneS),
    .oLAST_CMD (lastS)
  );

  int passCnt  = 0;
  int checkCnt = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passCnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  // Cycle counter for frame spacing
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Count oDONE pulses of the fast instance
  int doneCnt = 0;
  always @(posedge clk) begin
    if (done) begin
      doneCnt <= doneCnt + 1;
    end
  end

  // UART receiver for the fast instance, sampling mid-bit (cycle 2 of 4)
  logic       rxActive = 1'b0;
  int         rxCnt    = 0;
  logic [7:0] rxByte   = 8'h00;
  int         frameErr = 0;
  logic [7:0] rxQ[$];
  int         startQ[$];

  always @(negedge clk) begin
    if (rst) begin
      rxActive <= 1'b0;
    end else if (!rxActive) begin
      if (tx == 1'b0) begin
        rxActive <= 1'b1;
        rxCnt    <= 1;
        startQ.push_back(cyc);
      end
    end else begin
      rxCnt <= rxCnt + 1;
      if (rxCnt == 2) begin
        if (tx != 1'b0) frameErr <= frameErr + 1;
      end else if (rxCnt == 38) begin
        if (tx != 1'b1) frameErr <= frameErr + 1;
        rxQ.push_back(rxByte);
        rxActive <= 1'b0;
      end else if ((rxCnt % 4) == 2) begin
        rxByte <= {tx, rxByte[7:1]};
      end
    end
  end

  logic [39:0] wave;
  logic [39:0] expWave;
  logic [9:0]  frameBits;
  int          base;
  int          dBase;
  int          busyCycles;
  int          runLen;
  int          nRuns;
  int          runs[4];
  logic        level;

  initial begin
    rst   = 1'b1;
    cmd   = 8'h08;
    send  = 1'b0;
    rstS  = 1'b1;
    cmdS  = 8'h00;
    sendS = 1'b0;

    // ---------------- T0: reset and first command ----------------
    tickN(3);
    checkVal("t0_rst_tx",   64'(tx), 64'(1'b1));
    checkVal("t0_rst_busy", 64'(busy), 64'(1'b0));
    checkVal("t0_rst_done", 64'(done), 64'(1'b0));
    checkVal("t0_rst_last", 64'(lastCmd), 64'(8'h00));
    rst = 1'b0;
    tick();
    checkVal("t0_start_tx",   64'(tx), 64'(1'b0));
    checkVal("t0_start_busy", 64'(busy), 64'(1'b1));
    // 0x08: start, 0,0,0,1,0,0,0,0, stop (slot k at bit k)
    frameBits = 10'b10_0001_0000;
    wave[0] = tx;
    for (int i = 1; i < 40; i++) begin
      tick();
      wave[i] = tx;
    end
    for (int i = 0; i < 40; i++) begin
      expWave[i] = frameBits[i / 4];
    end
    checkVal("t0_wave", 64'(wave), 64'(expWave));
    tick();
    checkVal("t0_done_pulse", 64'(done), 64'(1'b1));
    checkVal("t0_end_busy",   64'(busy), 64'(1'b0));
    checkVal("t0_end_tx",     64'(tx), 64'(1'b1));
    checkVal("t0_last",       64'(lastCmd), 64'(8'h08));
    tick();
    checkVal("t0_done_once", 64'(done), 64'(1'b0));
    tickN(10);
    checkVal("t0_no_refire", 64'(busy), 64'(1'b0));
    checkVal("t0_rx_count",  64'(rxQ.size()), 64'(1));
    checkVal("t0_rx_byte",   64'(rxQ[0]), 64'(8'h08));
    checkVal("t0_done_cnt",  64'(doneCnt), 64'(1));

    // ---------------- T1: coalescing ----------------
    base  = rxQ.size();
    dBase = doneCnt;
    cmd = 8'h03;
    tickN(10);
    cmd = 8'h05;
    tickN(10);
    cmd = 8'h01;
    tickN(100);
    checkVal("t1_rx_count", 64'(rxQ.size() - base), 64'(2));
    checkVal("t1_first",    64'(rxQ[base]), 64'(8'h03));
    checkVal("t1_second",   64'(rxQ[base + 1]), 64'(8'h01));
    checkVal("t1_gap",      64'(startQ[base + 1] - startQ[base]), 64'(41));
    checkVal("t1_done_cnt", 64'(doneCnt - dBase), 64'(2));
    checkVal("t1_last",     64'(lastCmd), 64'(8'h01));

    // ---------------- T2: resend strobes ----------------
    cmd = 8'h02;
    tickN(50);
    checkVal("t2_setup_last", 64'(lastCmd), 64'(8'h02));
    base  = rxQ.size();
    dBase = doneCnt;
    send = 1'b1;
    tick();
    send = 1'b0;
    tickN(5);
    send = 1'b1;
    tick();
    send = 1'b0;
    tickN(10);
    send = 1'b1;
    tick();
    send = 1'b0;
    tickN(100);
    checkVal("t2_rx_count", 64'(rxQ.size() - base), 64'(2));
    checkVal("t2_first",    64'(rxQ[base]), 64'(8'h02));
    checkVal("t2_second",   64'(rxQ[base + 1]), 64'(8'h02));
    checkVal("t2_gap",      64'(startQ[base + 1] - startQ[base]), 64'(41));
    checkVal("t2_done_cnt", 64'(doneCnt - dBase), 64'(2));

    // ---------------- T3: reset mid-frame ----------------
    base  = rxQ.size();
    dBase = doneCnt;
    cmd = 8'h06;
    tick();
    checkVal("t3_start_tx", 64'(tx), 64'(1'b0));
    tickN(16);
    // first cycle of data bit 3; bit 3 of 0x06 is 0
    checkVal("t3_bit3", 64'(tx), 64'(1'b0));
    rst = 1'b1;
    tick();
    checkVal("t3_rst_tx",   64'(tx), 64'(1'b1));
    checkVal("t3_rst_busy", 64'(busy), 64'(1'b0));
    checkVal("t3_rst_last", 64'(lastCmd), 64'(8'h00));
    checkVal("t3_rst_done", 64'(done), 64'(1'b0));
    rst = 1'b0;
    tickN(60);
    checkVal("t3_rx_count", 64'(rxQ.size() - base), 64'(1));
    checkVal("t3_rx_byte",  64'(rxQ[base]), 64'(8'h06));
    checkVal("t3_last",     64'(lastCmd), 64'(8'h06));
    checkVal("t3_done_cnt", 64'(doneCnt - dBase), 64'(1));
    checkVal("frame_errors", 64'(frameErr), 64'(0));

    // ---------------- T4: default baud timing ----------------
    cmdS = 8'h07;
    tick();
    rstS = 1'b0;
    for (int i = 0; i < 5 && !busyS; i++) begin
      tick();
    end
    checkVal("t4_busy_rise", 64'(busyS), 64'(1'b1));
    checkVal("t4_start_tx",  64'(txS), 64'(1'b0));
    busyCycles = 0;
    runLen     = 0;
    nRuns      = 0;
    level      = txS;
    for (int i = 0; i < 4; i++) runs[i] = 0;
    while (busyS && busyCycles < 60000) begin
      busyCycles++;
      runLen++;
      tick();
      if (!busyS || txS != level) begin
        if (nRuns < 4) runs[nRuns] = runLen;
        nRuns++;
        runLen = 0;
        level  = txS;
      end
    end
    // 0x07 frame: 0 | 1,1,1 | 0,0,0,0,0 | 1
    checkVal("t4_busy_len", 64'(busyCycles), 64'(52080));
    checkVal("t4_run_count", 64'(nRuns), 64'(4));
    checkVal("t4_run_start", 64'(runs[0]), 64'(5208));
    checkVal("t4_run_ones",  64'(runs[1]), 64'(15624));
    checkVal("t4_run_zeros", 64'(runs[2]), 64'(26040));
    checkVal("t4_run_stop",  64'(runs[3]), 64'(5208));
    checkVal("t4_done",      64'(doneS), 64'(1'b1));
    checkVal("t4_last",      64'(lastS), 64'(8'h07));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
